// File: rtl/exec_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_seq_ctrl
// Description : PDP-8 execution sequencer. Owns the PC, stalls the decoder
//               and runs the memory read/write handshake per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_seq_ctrl #(
    parameter int                    ADDR_WIDTH    = 12,
    parameter int                    DATA_WIDTH    = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'h080,
    parameter int                    MEM_TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    input  logic [2:0]            instr_op,
    input  logic [ADDR_WIDTH-1:0] eff_addr,
    input  logic                  skip_in,
    input  logic [DATA_WIDTH-1:0] ac_in,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  opnd_valid,
    output logic [DATA_WIDTH-1:0] opnd,
    output logic                  ac_clr,
    output logic                  timeout_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;
    localparam logic [1:0] c_st_upd  = 2'd3;

    localparam logic [2:0] c_op_and = 3'd0;
    localparam logic [2:0] c_op_tad = 3'd1;
    localparam logic [2:0] c_op_isz = 3'd2;
    localparam logic [2:0] c_op_dca = 3'd3;
    localparam logic [2:0] c_op_jms = 3'd4;
    localparam logic [2:0] c_op_jmp = 3'd5;
    localparam logic [2:0] c_op_iot = 3'd6;
    localparam logic [2:0] c_op_opr = 3'd7;

    localparam logic [ADDR_WIDTH-1:0] c_pc_one   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_pc_two   = ADDR_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] c_data_one = DATA_WIDTH'(1);
    localparam logic [7:0]            c_wait_last = 8'(MEM_TIMEOUT - 1);

    logic [1:0]            r_state;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_eff_addr;
    logic                  r_skip;
    logic                  r_zero;
    logic [7:0]            r_wait_cnt;
    logic                  r_stall;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_opnd_valid;
    logic [DATA_WIDTH-1:0] r_opnd;
    logic                  r_ac_clr;
    logic                  r_timeout_err;

    logic [ADDR_WIDTH-1:0] w_pc_inc1;
    logic [ADDR_WIDTH-1:0] w_pc_inc2;
    logic                  w_timeout;

    assign w_pc_inc1 = r_pc + c_pc_one;
    assign w_pc_inc2 = r_pc + c_pc_two;
    // ack has priority: timeout only fires on a cycle the request is still unanswered
    assign w_timeout = r_mem_req && !mem_ack && (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_st_idle;
            r_op          <= 3'd0;
            r_eff_addr    <= '0;
            r_skip        <= 1'b0;
            r_zero        <= 1'b0;
            r_wait_cnt    <= 8'd0;
            r_stall       <= 1'b0;
            r_pc          <= START_ADDRESS;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_opnd_valid  <= 1'b0;
            r_opnd        <= '0;
            r_ac_clr      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_opnd_valid <= 1'b0;
            r_ac_clr     <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (instr_valid && !r_stall) begin
                        r_op       <= instr_op;
                        r_eff_addr <= eff_addr;
                        r_skip     <= skip_in;
                        r_stall    <= 1'b1;
                        r_wait_cnt <= 8'd0;
                        case (instr_op)
                            c_op_and, c_op_tad, c_op_isz: begin
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= eff_addr;
                                r_state    <= c_st_rd;
                            end
                            c_op_dca, c_op_jms: begin
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= eff_addr;
                                r_mem_wdata <= (instr_op == c_op_dca) ? ac_in
                                                                      : DATA_WIDTH'(w_pc_inc1);
                                r_state     <= c_st_wr;
                            end
                            default: r_state <= c_st_upd;
                        endcase
                    end
                end
                c_st_rd: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_op == c_op_isz) begin
                            // request drops for one cycle before the write-back is issued
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= mem_rdata + c_data_one;
                            r_zero      <= &mem_rdata;
                            r_wait_cnt  <= 8'd0;
                            r_state     <= c_st_wr;
                        end else begin
                            r_opnd       <= mem_rdata;
                            r_opnd_valid <= 1'b1;
                            r_pc         <= w_pc_inc1;
                            r_stall      <= 1'b0;
                            r_state      <= c_st_idle;
                        end
                    end else if (w_timeout) begin
                        r_mem_req     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_pc          <= w_pc_inc1;
                        r_stall       <= 1'b0;
                        r_state       <= c_st_idle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_st_wr: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_stall   <= 1'b0;
                        r_state   <= c_st_idle;
                        case (r_op)
                            c_op_isz: r_pc <= r_zero ? w_pc_inc2 : w_pc_inc1;
                            c_op_jms: r_pc <= r_eff_addr + c_pc_one;
                            default: begin
                                r_pc     <= w_pc_inc1;
                                r_ac_clr <= 1'b1;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_pc          <= w_pc_inc1;
                        r_stall       <= 1'b0;
                        r_state       <= c_st_idle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_stall <= 1'b0;
                    r_state <= c_st_idle;
                    case (r_op)
                        c_op_jmp: r_pc <= r_eff_addr;
                        c_op_opr: r_pc <= r_skip ? w_pc_inc2 : w_pc_inc1;
                        c_op_iot: r_pc <= w_pc_inc1;
                        default:  r_pc <= w_pc_inc1;
                    endcase
                end
            endcase
        end
    end

    assign stall       = r_stall;
    assign PC_value    = r_pc;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign opnd_valid  = r_opnd_valid;
    assign opnd        = r_opnd;
    assign ac_clr      = r_ac_clr;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
